// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: shared sample prescaler, per-channel 2-FF synchroniser,
// stability counter, registered press/release pulses and optional hold-to-repeat.
module debounce_multi #(
  parameter int unsigned         CHANNELS       = 4,
  parameter int unsigned         SAMPLE_DIV     = 250000,
  parameter int unsigned         STABLE_SAMPLES = 4,
  parameter int unsigned         REPEAT_DELAY   = 200,
  parameter int unsigned         REPEAT_RATE    = 40,
  parameter logic [CHANNELS-1:0] INVERT_MASK    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic                sample_tick
);

  localparam int unsigned DivW    = $clog2(SAMPLE_DIV);
  localparam int unsigned StabW   = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  localparam logic [DivW-1:0]  DivLast    = DivW'(SAMPLE_DIV - 1);
  localparam logic [StabW-1:0] StableLast = StabW'(STABLE_SAMPLES - 1);
  localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] RateLast   = HoldW'(REPEAT_RATE - 1);

  typedef enum logic {PhFirst, PhRate} phase_e;

  logic [DivW-1:0]     div_q, div_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [StabW-1:0]    stab_q  [CHANNELS];
  logic [StabW-1:0]    stab_d  [CHANNELS];
  logic [HoldW-1:0]    hold_q  [CHANNELS];
  logic [HoldW-1:0]    hold_d  [CHANNELS];
  phase_e              phase_q [CHANNELS];
  phase_e              phase_d [CHANNELS];

  assign sample_tick = (div_q == DivLast);
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  always_comb begin
    div_d = sample_tick ? '0 : div_q + DivW'(1);
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      stab_d[i]  = stab_q[i];
      hold_d[i]  = hold_q[i];
      phase_d[i] = phase_q[i];

      if (sample_tick) begin
        if (sync2_q[i] != level_q[i]) begin
          if (stab_q[i] == StableLast) begin
            level_d[i] = ~level_q[i];
            stab_d[i]  = '0;
          end else begin
            stab_d[i] = stab_q[i] + StabW'(1);
          end
        end else begin
          stab_d[i] = '0;
        end
      end

      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];

      // Held only while the level stays high through this edge, so a repeat never lands
      // on the same cycle as the release pulse.
      if (level_q[i] && level_d[i] && repeat_en[i]) begin
        if (sample_tick) begin
          if (hold_q[i] == ((phase_q[i] == PhFirst) ? DelayLast : RateLast)) begin
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
            phase_d[i] = PhRate;
          end else begin
            hold_d[i] = hold_q[i] + HoldW'(1);
          end
        end
      end else begin
        hold_d[i]  = '0;
        phase_d[i] = PhFirst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_q[i]  <= '0;
        hold_q[i]  <= '0;
        phase_q[i] <= PhFirst;
      end
    end else begin
      div_q     <= div_d;
      sync1_q   <= btn_in ^ INVERT_MASK;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_q[i]  <= stab_d[i];
        hold_q[i]  <= hold_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised bench for debounce_multi, checked every cycle against a tick-level behavioural model.
module tb_debounce_multi;

  localparam int        CH     = 2;
  localparam int        DIV    = 4;
  localparam int        STABLE = 3;
  localparam int        RDELAY = 5;
  localparam int        RRATE  = 2;
  localparam logic [1:0] MASK  = 2'b10;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic          sample_tick;

  int n_cmp;
  int n_err;

  debounce_multi #(
    .CHANNELS      (CH),
    .SAMPLE_DIV    (DIV),
    .STABLE_SAMPLES(STABLE),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_RATE   (RRATE),
    .INVERT_MASK   (MASK)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycle count since reset, a 2-deep input delay line, a run length of
  // disagreeing samples, and a count of ticks held since the last press/repeat.
  int k;
  bit s1    [CH];
  bit s2    [CH];
  bit lvl   [CH];
  int run   [CH];
  int held  [CH];
  bit first [CH];
  bit prs   [CH];
  bit rls   [CH];

  // Stimulus state
  bit pressed [CH];
  int dur     [CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < CH; c++) begin
      s1[c] = 0; s2[c] = 0; lvl[c] = 0; run[c] = 0; held[c] = 0;
      first[c] = 1; prs[c] = 0; rls[c] = 0;
    end
  endtask

  function automatic bit model_tick();
    return (k % DIV) == (DIV - 1);
  endfunction

  task automatic model_step(input logic [CH-1:0] btn, input logic [CH-1:0] ren);
    bit tick;
    bit nl;
    int target;
    tick = model_tick();
    for (int c = 0; c < CH; c++) begin
      nl = lvl[c];
      prs[c] = 0;
      rls[c] = 0;
      if (tick) begin
        if (s2[c] != lvl[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == STABLE) begin
            nl = !lvl[c];
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
      if (nl && !lvl[c]) prs[c] = 1;
      if (!nl && lvl[c]) rls[c] = 1;
      if (lvl[c] && nl && ren[c]) begin
        if (tick) begin
          held[c] = held[c] + 1;
          target = first[c] ? RDELAY : RRATE;
          if (held[c] == target) begin
            prs[c] = 1;
            held[c] = 0;
            first[c] = 0;
          end
        end
      end else begin
        held[c] = 0;
        first[c] = 1;
      end
      lvl[c] = nl;
      s2[c] = s1[c];
      s1[c] = btn[c] ^ MASK[c];
    end
    k++;
  endtask

  task automatic compare_all(input string tag);
    logic [CH-1:0] el, ep, er;
    for (int c = 0; c < CH; c++) begin
      el[c] = lvl[c];
      ep[c] = prs[c];
      er[c] = rls[c];
    end
    check_eq({tag, "_level"},   32'(btn_level),   32'(el));
    check_eq({tag, "_press"},   32'(btn_press),   32'(ep));
    check_eq({tag, "_release"}, 32'(btn_release), 32'(er));
    check_eq({tag, "_tick"},    32'(sample_tick), 32'(model_tick()));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_level"},   32'(btn_level),   32'(0));
    check_eq({tag, "_press"},   32'(btn_press),   32'(0));
    check_eq({tag, "_release"}, 32'(btn_release), 32'(0));
    check_eq({tag, "_tick"},    32'(sample_tick), 32'(0));
  endtask

  // Pick next inputs (mix of sub-debounce glitches and long holds), drive them, advance model.
  task automatic do_step();
    logic [CH-1:0] b;
    logic [CH-1:0] r;
    r = repeat_en;
    for (int c = 0; c < CH; c++) begin
      if (dur[c] == 0) begin
        pressed[c] = !pressed[c];
        if ($urandom_range(0, 9) < 4) dur[c] = $urandom_range(1, 9);
        else dur[c] = $urandom_range(14, 160);
      end else begin
        dur[c]--;
      end
      b[c] = pressed[c] ^ MASK[c];
      if ($urandom_range(0, 149) == 0) r[c] = !r[c];
    end
    btn_in = b;
    repeat_en = r;
    model_step(b, r);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    btn_in = MASK;
    repeat_en = '0;
    for (int c = 0; c < CH; c++) begin
      pressed[c] = 0;
      dur[c] = $urandom_range(3, 20);
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    do_step();
    for (int n = 0; n < 20000; n++) begin
      if (n == 3000 || n == 9001 || $urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        check_zero("in_rst");
        rst_n = 1'b1;
        model_reset();
        do_step();
      end else begin
        @(negedge clk);
        compare_all("run");
        do_step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised successor to the single-button debouncer. Conditions CHANNELS independent mechanical inputs, such as push-buttons and switches, using one shared sample-tick prescaler. Each channel has a 2-FF synchroniser and a stability counter. Each channel outputs a clean level, a one-cycle press pulse, a one-cycle release pulse and optional hold-to-repeat press pulses. Sits between board pins and the monitor-tester control FSM.

Parameters:
CHANNELS, 4, number of independent inputs (>=1)
SAMPLE_DIV, 250000, clk cycles per sample tick (>=2); 2.5 ms at 100 MHz
STABLE_SAMPLES, 4, consecutive differing samples required to accept a new level (>=1)
REPEAT_DELAY, 200, sample ticks a press must be held before the first repeat pulse (>=1)
REPEAT_RATE, 40, sample ticks between subsequent repeat pulses (>=1)
INVERT_MASK, {CHANNELS{1'b0}}, per-channel bit; 1 = input is active-low and is inverted before the synchroniser

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
btn_in  in  CHANNELS  raw asynchronous button/switch inputs
repeat_en  in  CHANNELS  per-channel enable for auto-repeat
btn_level  out  CHANNELS  debounced level, 1 = pressed
btn_press  out  CHANNELS  one-clk pulse on accepted press and on each repeat
btn_release  out  CHANNELS  one-clk pulse on accepted release
sample_tick  out  1  one-clk strobe, the shared sample enable

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler, sync FFs, stability counters and hold counters are 0. All outputs are 0. Effective inputs are treated as released.
- Effective input: eff[i] = btn_in[i] XOR INVERT_MASK[i]. This feeds a 2-FF synchroniser clocked every clk. sync[i] is the second FF output.
- Prescaler: counts 0..SAMPLE_DIV-1, then wraps to 0. sample_tick=1 exactly in the cycle the count equals SAMPLE_DIV-1. First tick occurs SAMPLE_DIV cycles after reset release.
- Stability, per channel, evaluated only when sample_tick=1:
  - If sync != btn_level, stab_cnt increments.
  - If sync == btn_level, stab_cnt clears to 0.
  - When the increment would make stab_cnt reach STABLE_SAMPLES, btn_level toggles on that clock edge and stab_cnt clears.
- A single agreeing sample anywhere in a run restarts the count; this is the glitch-rejection rule.
- Pulses are registered:
  - btn_press[i]=1 for exactly the cycle in which btn_level[i] is first 1.
  - btn_release[i]=1 for exactly the cycle in which btn_level[i] is first 0.
  - Otherwise both are 0. Pulses for different channels are fully independent and may coincide.
- Auto-repeat, per channel, uses a hold counter that advances only on sample_tick:
  - Active only while btn_level=1 and repeat_en=1. Otherwise the hold counter is held at 0 and its phase is FIRST.
  - In phase FIRST: after REPEAT_DELAY ticks of continuous hold, emit a btn_press pulse in the cycle after that tick. Clear the counter and enter phase RATE.
  - In phase RATE: emit a pulse every REPEAT_RATE ticks.
  - Deasserting repeat_en mid-hold clears the counter and returns to FIRST, with no pulse. Re-asserting it restarts the REPEAT_DELAY count.
  - The release edge clears the counter and returns to FIRST; a repeat and a release never coincide.
- Latency: a clean input step reaches sync after 2 clk. btn_level changes one clk after the STABLE_SAMPLES-th qualifying tick. Worst case is 2 + SAMPLE_DIV*STABLE_SAMPLES + 1 clk.
- Widths: prescaler is $clog2(SAMPLE_DIV) bits; stab_cnt is $clog2(STABLE_SAMPLES+1) bits. Hold counter is $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) bits. No counter may overflow or wrap except the prescaler.
- STABLE_SAMPLES=1: the level follows the first differing sample.
- Input toggling every tick: btn_level never changes while STABLE_SAMPLES>1.
- Reset mid-hold or mid-count: everything returns to the reset state immediately, with no release pulse generated.

Test Plan:
Bench parameters: CHANNELS=2, SAMPLE_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2, INVERT_MASK=2'b10.
- Reset and tick: hold rst_n=0, then release, with btn_in=2'b10 (both inputs idle). Expect all outputs 0 and sample_tick every 4th clk (first at clk 4). Expect btn_level=00 indefinitely.
- Clean press ch0: btn_in[0] 0->1 and held. Expect btn_level[0] to rise one clk after the 3rd tick following sync. Expect one btn_press[0] pulse of width 1 and no pulse on ch1.
- Glitch rejection: btn_in[0] pulses high for 2 ticks, low for 1 tick, then high for 2 ticks. Expect btn_level[0] to stay 0 and no pulses.
- Inverted channel: drive btn_in[1] 1->0. Expect the ch1 press after 3 ticks. Drive it back to 1; expect one btn_release[1] pulse after 3 ticks.
- Auto-repeat: repeat_en[0]=1 with ch0 held. Expect the initial press, then a press 5 ticks later, then a press every 2 ticks. Drop repeat_en mid-hold; expect pulses to stop. Release ch0; expect a single release pulse.
- Async reset mid-count: assert rst_n=0 between clk edges after 2 qualifying ticks. Expect outputs 0 immediately. After release, expect a full 3 ticks to be required again.
